// File: rtl/tthbif_pkg.sv
// Shared definitions for the tthbif configuration controller:
// register addresses, command byte layout, ID default and FSM states.
package tthbif_pkg;

  // Register map
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_RX_FLOP = 3'd1;
  localparam logic [2:0] ADDR_RX_COMB = 3'd2;
  localparam logic [2:0] ADDR_TX_FLOP = 3'd3;
  localparam logic [2:0] ADDR_TX_COMB = 3'd4;
  localparam logic [2:0] ADDR_ID      = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;
  localparam logic [2:0] ADDR_STATUS  = 3'd7;

  // Command byte layout: {write, reserved[3:0], addr[2:0]}
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_RSVD_HI   = 6;
  localparam int CMD_RSVD_LO   = 3;
  localparam int CMD_ADDR_HI   = 2;
  localparam int CMD_ADDR_LO   = 0;

  localparam logic [7:0] ID_DEFAULT = 8'hB1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // A command byte is legal only when its reserved field is zero.
  function automatic logic cmd_is_legal(input logic [7:0] b);
    return (b[CMD_RSVD_HI:CMD_RSVD_LO] == 4'd0);
  endfunction

endpackage

// File: rtl/tthbif_cfg_ctrl.sv
// Byte-stream command decoder and register file driving the tthbif
// enable and the rx/tx flop/comb tap selects.
//
// Handshakes:
//   rx side is valid-only: a byte is consumed in every cycle that
//   rx_data_valid_i is high, there is no back-pressure.
//   tx side is strict valid/ready: tx_data_o and tx_data_valid_o are held
//   stable while valid is high and ready is low; a byte is transferred on
//   a rising clock edge where both are high, after which valid drops.
//
// dbg_state_o exposes the FSM state for observation only.
module tthbif_cfg_ctrl
  import tthbif_pkg::*;
#(
  parameter int          NUM_FLOP_TAP   = 4,
  parameter int          NUM_COMB_TAP   = 4,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ID_VALUE       = ID_DEFAULT,
  localparam int         FW = (NUM_FLOP_TAP > 1) ? $clog2(NUM_FLOP_TAP) : 1,
  localparam int         CW = (NUM_COMB_TAP > 1) ? $clog2(NUM_COMB_TAP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_data_valid_i,
  input  logic [7:0]    rx_data_i,
  input  logic          tx_data_ready_i,
  output logic          tx_data_valid_o,
  output logic [7:0]    tx_data_o,
  input  logic [7:0]    status_i,
  output logic          tthbif_en_o,
  output logic [FW-1:0] rx_flop_tap_sel_o,
  output logic [CW-1:0] rx_comb_tap_sel_o,
  output logic [FW-1:0] tx_flop_tap_sel_o,
  output logic [CW-1:0] tx_comb_tap_sel_o,
  output state_e        dbg_state_o
);

  localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      addr_q, addr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            en_q, en_d;
  logic [FW-1:0]   rx_flop_q, rx_flop_d;
  logic [CW-1:0]   rx_comb_q, rx_comb_d;
  logic [FW-1:0]   tx_flop_q, tx_flop_d;
  logic [CW-1:0]   tx_comb_q, tx_comb_d;
  logic [7:0]      scratch_q, scratch_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;
  logic            tmo_q, tmo_d;

  logic            set_err, set_ovr, set_tmo, clr_flags;
  logic [2:0]      cmd_addr;
  logic [7:0]      rd_data;

  // Only the upper five status bits are reported; the low three carry flags.
  logic            unused_status;
  assign unused_status = ^status_i[2:0];

  assign cmd_addr = rx_data_i[CMD_ADDR_HI:CMD_ADDR_LO];

  // Read mux, addressed directly by the incoming command byte so the
  // response (and the STATUS snapshot) is captured in the decode cycle.
  always_comb begin
    rd_data = 8'h00;
    case (cmd_addr)
      ADDR_CTRL:    rd_data = {7'd0, en_q};
      ADDR_RX_FLOP: rd_data = 8'(rx_flop_q);
      ADDR_RX_COMB: rd_data = 8'(rx_comb_q);
      ADDR_TX_FLOP: rd_data = 8'(tx_flop_q);
      ADDR_TX_COMB: rd_data = 8'(tx_comb_q);
      ADDR_ID:      rd_data = ID_VALUE;
      ADDR_SCRATCH: rd_data = scratch_q;
      ADDR_STATUS:  rd_data = {status_i[7:3], err_q, ovr_q, tmo_q};
      default:      rd_data = 8'h00;
    endcase
  end

  // Next-state, register-file update, response and sticky flag logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    en_d       = en_q;
    rx_flop_d  = rx_flop_q;
    rx_comb_d  = rx_comb_q;
    tx_flop_d  = tx_flop_q;
    tx_comb_d  = tx_comb_q;
    scratch_d  = scratch_q;
    set_err    = 1'b0;
    set_ovr    = 1'b0;
    set_tmo    = 1'b0;
    clr_flags  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid_i) begin
          if (!cmd_is_legal(rx_data_i)) begin
            set_err = 1'b1;
          end else if (rx_data_i[CMD_WRITE_BIT]) begin
            addr_d  = cmd_addr;
            timer_d = '0;
            state_d = ST_WDATA;
          end else begin
            tx_data_d  = rd_data;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
            if (cmd_addr == ADDR_STATUS) begin
              clr_flags = 1'b1;
            end
          end
        end
      end

      ST_WDATA: begin
        // A data byte on the final timer count still wins over the timeout.
        if (rx_data_valid_i) begin
          case (addr_q)
            ADDR_CTRL:    en_d      = rx_data_i[0];
            ADDR_RX_FLOP: rx_flop_d = rx_data_i[FW-1:0];
            ADDR_RX_COMB: rx_comb_d = rx_data_i[CW-1:0];
            ADDR_TX_FLOP: tx_flop_d = rx_data_i[FW-1:0];
            ADDR_TX_COMB: tx_comb_d = rx_data_i[CW-1:0];
            ADDR_SCRATCH: scratch_d = rx_data_i;
            default:      ;  // ID and STATUS are read-only; write dropped silently
          endcase
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          set_tmo = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rx_data_valid_i) begin
          set_ovr = 1'b1;
        end
        if (tx_data_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // Sticky flags: a set in the same cycle as a STATUS-read clear wins.
    err_d = set_err | (err_q & ~clr_flags);
    ovr_d = set_ovr | (ovr_q & ~clr_flags);
    tmo_d = set_tmo | (tmo_q & ~clr_flags);
  end

  // State, register file and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= 3'd0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      en_q       <= 1'b0;
      rx_flop_q  <= '1;
      rx_comb_q  <= '1;
      tx_flop_q  <= '1;
      tx_comb_q  <= '1;
      scratch_q  <= 8'h00;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      en_q       <= en_d;
      rx_flop_q  <= rx_flop_d;
      rx_comb_q  <= rx_comb_d;
      tx_flop_q  <= tx_flop_d;
      tx_comb_q  <= tx_comb_d;
      scratch_q  <= scratch_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_data_valid_o   = tx_valid_q;
  assign tx_data_o         = tx_data_q;
  assign tthbif_en_o       = en_q;
  assign rx_flop_tap_sel_o = rx_flop_q;
  assign rx_comb_tap_sel_o = rx_comb_q;
  assign tx_flop_tap_sel_o = tx_flop_q;
  assign tx_comb_tap_sel_o = tx_comb_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_tthbif_cfg_ctrl.sv
// Testbench for tthbif_cfg_ctrl: table-driven vectors, hand-written
// multi-cycle sequences and a randomized run against a register-map model.
module tb_tthbif_cfg_ctrl;
  import tthbif_pkg::*;

  localparam int         NFT = 4;
  localparam int         NCT = 4;
  localparam int         TMO = 20;
  localparam logic [7:0] IDV = 8'hB1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [7:0] status = 8'h00;
  logic       en;
  logic [1:0] rx_flop, rx_comb, tx_flop, tx_comb;
  state_e     dbg_state;

  always #5 clk = ~clk;

  tthbif_cfg_ctrl #(
    .NUM_FLOP_TAP   (NFT),
    .NUM_COMB_TAP   (NCT),
    .TIMEOUT_CYCLES (TMO),
    .ID_VALUE       (IDV)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rx_data_valid_i   (rx_valid),
    .rx_data_i         (rx_data),
    .tx_data_ready_i   (tx_ready),
    .tx_data_valid_o   (tx_valid),
    .tx_data_o         (tx_data),
    .status_i          (status),
    .tthbif_en_o       (en),
    .rx_flop_tap_sel_o (rx_flop),
    .rx_comb_tap_sel_o (rx_comb),
    .tx_flop_tap_sel_o (tx_flop),
    .tx_comb_tap_sel_o (tx_comb),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Register contents as plain integers plus the three sticky flags.
  int m_reg[8];
  bit m_err, m_ovr, m_tmo;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_reg[1] = NFT - 1;
    m_reg[2] = NCT - 1;
    m_reg[3] = NFT - 1;
    m_reg[4] = NCT - 1;
    m_err = 0; m_ovr = 0; m_tmo = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    case (a)
      0:       m_reg[0] = d % 2;
      1, 3:    m_reg[a] = d % NFT;
      2, 4:    m_reg[a] = d % NCT;
      6:       m_reg[6] = d % 256;
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input int a);
    logic [7:0] r;
    if (a == 5) r = IDV;
    else if (a == 7) begin
      r = {status[7:3], m_err, m_ovr, m_tmo};
      m_err = 0; m_ovr = 0; m_tmo = 0;
    end else r = 8'(m_reg[a]);
    return r;
  endfunction

  task automatic check_cfg(input string tag);
    check({tag, ".en"},      32'(en),      32'(m_reg[0]));
    check({tag, ".rx_flop"}, 32'(rx_flop), 32'(m_reg[1]));
    check({tag, ".rx_comb"}, 32'(rx_comb), 32'(m_reg[2]));
    check({tag, ".tx_flop"}, 32'(tx_flop), 32'(m_reg[3]));
    check({tag, ".tx_comb"}, 32'(tx_comb), 32'(m_reg[4]));
  endtask

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge; outputs are
  // sampled at the same point, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input int gap);
    send_byte({1'b1, 4'b0000, a});
    repeat (gap) tick();
    send_byte(d);
    model_write(int'(a), int'(d));
    check_cfg("wr_cfg");
    check("wr_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Issue a read, hold ready low for 'delay' cycles, optionally inject an
  // rx byte during the response, then accept the byte.
  task automatic do_read(input logic [2:0] a, input int delay, input bit inject,
                         input bit use_tbl, input logic [7:0] tbl_exp);
    logic [7:0] e;
    e = model_read(int'(a));
    if (use_tbl) e = tbl_exp;
    exp_q.push_back(e);
    send_byte({1'b0, 4'b0000, a});
    for (int i = 0; i < delay; i++) begin
      check("rd_hold_valid", 32'(tx_valid), 32'd1);
      check("rd_hold_data", 32'(tx_data), 32'(exp_q[0]));
      check("rd_hold_state", 32'(dbg_state), 32'(ST_RESP));
      if (inject && i == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'h81;
        m_ovr    = 1;
      end
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
    check("rd_valid", 32'(tx_valid), 32'd1);
    check("rd_data", 32'(tx_data), 32'(exp_q.pop_front()));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("rd_drop_valid", 32'(tx_valid), 32'd0);
    check("rd_drop_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic check_defaults(input string tag);
    check({tag, ".valid"}, 32'(tx_valid), 32'd0);
    check({tag, ".data"},  32'(tx_data),  32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, ".en"},    32'(en),       32'd0);
    check({tag, ".sels"},  32'({rx_flop, rx_comb, tx_flop, tx_comb}), 32'hFF);
  endtask

  // ---------------- vector table ----------------
  // kind: 0 = write, 1 = read (exp compared), 2 = illegal byte in data field
  typedef struct {
    int         kind;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] stat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int k, input logic [2:0] a, input logic [7:0] d,
                              input logic [7:0] s, input logic [7:0] x);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.stat = s; v.exp = x;
    tbl.push_back(v);
  endfunction

  // Safety net against a stuck simulation.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vec_cnt);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         op;

    // ---- reset ----
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_defaults("reset");
    rst_n = 1'b1;
    tick();
    check_defaults("post_reset");

    // ---- table ----
    add(0, 3'd1, 8'h02, 8'h00, 8'h00);  // rx 81,02 -> rx_flop = 2
    add(1, 3'd1, 8'h00, 8'h00, 8'h02);
    add(1, 3'd5, 8'h00, 8'h00, 8'hB1);
    add(0, 3'd6, 8'hA5, 8'h00, 8'h00);
    add(1, 3'd6, 8'h00, 8'h00, 8'hA5);
    add(0, 3'd0, 8'hFF, 8'h00, 8'h00);
    add(1, 3'd0, 8'h00, 8'h00, 8'h01);
    add(0, 3'd2, 8'hFE, 8'h00, 8'h00);  // upper bits dropped
    add(1, 3'd2, 8'h00, 8'h00, 8'h02);
    add(0, 3'd3, 8'h01, 8'h00, 8'h00);
    add(1, 3'd3, 8'h00, 8'h00, 8'h01);
    add(0, 3'd4, 8'h07, 8'h00, 8'h00);
    add(1, 3'd4, 8'h00, 8'h00, 8'h03);
    add(0, 3'd5, 8'h00, 8'h00, 8'h00);  // ID read-only
    add(1, 3'd5, 8'h00, 8'h00, 8'hB1);
    add(0, 3'd7, 8'hFF, 8'h00, 8'h00);  // STATUS read-only
    add(1, 3'd7, 8'h00, 8'hA8, 8'hA8);
    add(2, 3'd0, 8'h48, 8'h00, 8'h00);  // illegal -> err
    add(1, 3'd7, 8'h00, 8'h00, 8'h04);
    add(1, 3'd7, 8'h00, 8'h00, 8'h00);  // cleared by previous read
    add(0, 3'd0, 8'h00, 8'h00, 8'h00);
    add(1, 3'd0, 8'h00, 8'h00, 8'h00);

    foreach (tbl[i]) begin
      status = tbl[i].stat;
      case (tbl[i].kind)
        0: do_write(tbl[i].addr, tbl[i].data, 0);
        1: do_read(tbl[i].addr, 0, 1'b0, 1'b1, tbl[i].exp);
        default: begin
          send_byte(tbl[i].data);
          m_err = 1;
          check("illegal_state", 32'(dbg_state), 32'(ST_IDLE));
        end
      endcase
    end
    status = 8'h00;

    // ---- read ID with 10 cycles of back-pressure ----
    do_read(ADDR_ID, 10, 1'b0, 1'b0, 8'h00);

    // ---- timeout ----
    send_byte(8'h86);
    repeat (TMO - 1) tick();
    check("tmo_before", 32'(dbg_state), 32'(ST_WDATA));
    tick();
    check("tmo_after", 32'(dbg_state), 32'(ST_IDLE));
    m_tmo = 1;
    do_read(ADDR_SCRATCH, 0, 1'b0, 1'b0, 8'h00);
    do_read(ADDR_STATUS, 0, 1'b0, 1'b1, 8'h01);
    do_read(ADDR_STATUS, 0, 1'b0, 1'b1, 8'h00);
    // Data byte on the second-to-last timer count is still accepted.
    do_write(ADDR_SCRATCH, 8'h3C, TMO - 2);
    do_read(ADDR_SCRATCH, 0, 1'b0, 1'b1, 8'h3C);

    // ---- overrun during response ----
    do_read(ADDR_SCRATCH, 3, 1'b1, 1'b0, 8'h00);
    do_read(ADDR_STATUS, 0, 1'b0, 1'b1, 8'h02);
    send_byte(8'h48);
    m_err = 1;
    do_read(ADDR_STATUS, 0, 1'b0, 1'b1, 8'h04);

    // ---- reset in WDATA ----
    do_write(ADDR_CTRL, 8'h01, 0);
    do_write(ADDR_SCRATCH, 8'h77, 0);
    send_byte(8'h86);
    check("rst_wdata_pre", 32'(dbg_state), 32'(ST_WDATA));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_defaults("rst_wdata");
    tick();
    rst_n = 1'b1;
    tick();
    do_read(ADDR_SCRATCH, 0, 1'b0, 1'b1, 8'h00);

    // ---- reset in RESP ----
    send_byte(8'h05);
    check("rst_resp_pre", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_defaults("rst_resp");
    tick();
    rst_n = 1'b1;
    tick();
    do_write(ADDR_SCRATCH, 8'h5A, 0);
    do_read(ADDR_SCRATCH, 0, 1'b0, 1'b1, 8'h5A);

    // ---- randomized run against the model ----
    for (int n = 0; n < 300; n++) begin
      status = 8'($urandom);
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        do_write(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)));
      end else if (op < 8) begin
        if ($urandom_range(0, 3) == 0)
          do_read(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 1'b1, 1'b0, 8'h00);
        else
          do_read(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 8'h00);
      end else if (op == 8) begin
        b = 8'($urandom);
        b[6:3] = 4'($urandom_range(1, 15));
        send_byte(b);
        m_err = 1;
        check("rnd_illegal_state", 32'(dbg_state), 32'(ST_IDLE));
      end else begin
        do_read(ADDR_STATUS, 0, 1'b0, 1'b0, 8'h00);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
